uart_rx_core: RTL and testbench

UART receiver; the receive-side counterpart to the baud divider. It oversamples the asynchronous serial line on the system clock, using the same runtime divisor i_div_num (system clocks per bit). Each bit is sampled at its centre. Received bytes are presented on a valid/ready stream interface with per-frame error flags. It sits between the pad-side rx pin and the register/FIFO layer of the UART IP.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_core_if.sv | 40 ++++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx_core.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and constants
package uart_pkg;

    localparam int UART_DIV_W = 24;
    localparam logic [UART_DIV_W-1:0] UART_DIV_MIN = 24'd2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

    // Divisors below the minimum cannot place a half-bit sample point, so clamp them.
    function automatic logic [UART_DIV_W-1:0] uart_eff_div(input logic [UART_DIV_W-1:0] i_div);
        return (i_div < UART_DIV_MIN) ? UART_DIV_MIN : i_div;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-byte valid/ready stream with frame status flags
// o_break exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_core_if #(
    parameter int P_DATA_BITS = 8
);
    logic [P_DATA_BITS-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_frame_err;
    logic                   o_parity_err;
    logic                   o_overrun;
`ifdef UART_RX_BREAK_DET_EN
    logic                   o_break;
`endif

    modport master (
        output o_data,
        output o_valid,
        input  i_ready,
        output o_frame_err,
        output o_parity_err,
`ifdef UART_RX_BREAK_DET_EN
        output o_break,
`endif
        output o_overrun
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready,
        input  o_frame_err,
        input  o_parity_err,
`ifdef UART_RX_BREAK_DET_EN
        input  o_break,
`endif
        input  o_overrun
    );

endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-stage synchronizer for an async input, resets to 1 (idle line)
module uart_sync #(
    parameter int P_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [P_STAGES-1:0] r_sync;

    // Shift the async input through the flop chain; the last stage is safe to use.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[P_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[P_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver, centre-sampled bits, optional break detect via UART_RX_BREAK_DET_EN
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS   = 8,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [UART_DIV_W-1:0] i_div_num,
    input  logic                  i_parity_en,
    input  logic                  i_parity_odd,
    input  logic                  i_rx,
    output logic                  o_busy,
    uart_rx_core_if.master        rx_if
);

    logic                   w_rx_s;
    logic                   r_rx_prev;
    logic                   w_fall;

    uart_state_e            r_state;
    uart_state_e            w_next;

    logic [UART_DIV_W-1:0]  r_div;
    logic [UART_DIV_W-1:0]  r_cnt;
    logic [UART_DIV_W-1:0]  w_half;
    logic                   w_half_hit;
    logic                   w_bit_end;

    logic                   w_latch;
    logic                   w_start_ok;
    logic                   w_data_smp;
    logic                   w_par_smp;
    logic                   w_stop_smp;

    logic [P_DATA_BITS-1:0] r_shift;
    logic [3:0]             r_bit_idx;
    logic                   r_par_err;

    logic                   w_deliver;
    logic                   w_load;
    logic                   w_drop;

    logic [P_DATA_BITS-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;

    uart_sync #(
        .P_STAGES (P_SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    // Remember the previous synced level to detect the start-bit falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_s;
        end
    end

    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_half     = r_div >> 1;
    assign w_half_hit = (r_cnt == (w_half - 24'd1));
    assign w_bit_end  = (r_cnt == (r_div - 24'd1));

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and sample strobes: start checked at half-bit, later bits at end of period.
    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_start_ok = 1'b0;
        w_data_smp = 1'b0;
        w_par_smp  = 1'b0;
        w_stop_smp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_latch = 1'b1;
                    w_next  = START;
                end
            end
            START: begin
                if (w_half_hit) begin
                    if (w_rx_s) begin
                        w_next = IDLE;
                    end else begin
                        w_start_ok = 1'b1;
                        w_next     = DATA;
                    end
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_data_smp = 1'b1;
                    if (r_bit_idx == 4'(P_DATA_BITS - 1)) begin
                        w_next = i_parity_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_par_smp = 1'b1;
                    w_next    = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_stop_smp = 1'b1;
                    w_next     = w_rx_s ? IDLE : BREAK_WAIT;
                end
            end
            BREAK_WAIT: begin
                if (w_rx_s) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the divisor on the start edge and run the per-bit clock counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= UART_DIV_MIN;
            r_cnt <= '0;
        end else if (w_latch) begin
            r_div <= uart_eff_div(i_div_num);
            r_cnt <= '0;
        end else if (w_start_ok) begin
            r_cnt <= '0;
        end else if (r_state == START || r_state == DATA ||
                     r_state == PARITY || r_state == STOP) begin
            r_cnt <= w_bit_end ? '0 : (r_cnt + 24'd1);
        end
    end

    // Shift data in LSB first and evaluate parity against the received data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par_err <= 1'b0;
        end else if (w_start_ok) begin
            r_bit_idx <= '0;
            r_par_err <= 1'b0;
        end else if (w_data_smp) begin
            r_shift   <= {w_rx_s, r_shift[P_DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 4'd1;
        end else if (w_par_smp) begin
            r_par_err <= ((^r_shift) ^ w_rx_s) != i_parity_odd;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic r_par_bit;
    logic w_break;
    logic r_break;

    // Keep the received parity bit so an all-zero break frame can be recognised.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_par_bit <= 1'b0;
        end else if (w_start_ok) begin
            r_par_bit <= 1'b0;
        end else if (w_par_smp) begin
            r_par_bit <= w_rx_s;
        end
    end

    assign w_break   = w_stop_smp & ~w_rx_s & (r_shift == '0) & (~i_parity_en | ~r_par_bit);
    assign w_deliver = w_stop_smp & ~w_break;

    // Break is reported as a pulse instead of a delivered byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_break <= 1'b0;
        end else begin
            r_break <= w_break;
        end
    end

    assign rx_if.o_break = r_break;
`else
    assign w_deliver = w_stop_smp;
`endif

    assign w_load = w_deliver & (~r_valid | rx_if.i_ready);
    assign w_drop = w_deliver & r_valid & ~rx_if.i_ready;

    // Output holding register: load a completed frame if the slot is free, else flag overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_load) begin
                r_data       <= r_shift;
                r_frame_err  <= ~w_rx_s;
                r_parity_err <= r_par_err;
                r_valid      <= 1'b1;
            end else if (r_valid && rx_if.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.o_data       = r_data;
    assign rx_if.o_valid      = r_valid;
    assign rx_if.o_frame_err  = r_frame_err;
    assign rx_if.o_parity_err = r_parity_err;
    assign rx_if.o_overrun    = r_overrun;
    assign o_busy             = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] i_div_num;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_rx;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    int  ovr_cnt   = 0;
    int  vrise_cnt = 0;
    int  brk_cnt   = 0;
    logic prev_valid = 1'b0;

    uart_rx_core_if #(.P_DATA_BITS(8)) rx_if ();

    uart_rx_core #(
        .P_DATA_BITS   (8),
        .P_SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_div_num    (i_div_num),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_rx         (i_rx),
        .o_busy       (o_busy),
        .rx_if        (rx_if)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_if.o_overrun) ovr_cnt++;
        if (rx_if.o_valid && !prev_valid) vrise_cnt++;
        prev_valid = rx_if.o_valid;
`ifdef UART_RX_BREAK_DET_EN
        if (rx_if.o_break) brk_cnt++;
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb, input bit sb, input int div);
        int bt;
        bt = (div < 2) ? 2 : div;
        i_rx = 1'b0;
        tick(bt);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            tick(bt);
        end
        if (pe) begin
            i_rx = pb;
            tick(bt);
        end
        i_rx = sb;
        tick(bt);
        i_rx = 1'b1;
    endtask

    task automatic wait_valid(output int lat, input int bound);
        lat = 0;
        while (!rx_if.o_valid && lat < bound) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic accept();
        rx_if.i_ready = 1'b1;
        tick(1);
        rx_if.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_rx = 1'b1;
        rx_if.i_ready = 1'b0;
        i_div_num = 24'd16;
        i_parity_en = 1'b0;
        i_parity_odd = 1'b0;
        tick(3);
        total++; if (rx_if.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_if.o_valid); end
        total++; if (rx_if.o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_if.o_data); end
        total++; if ({rx_if.o_frame_err, rx_if.o_parity_err, rx_if.o_overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {rx_if.o_frame_err, rx_if.o_parity_err, rx_if.o_overrun}); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        int lat;
        i_div_num = 24'd16;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16);
            wait_valid(lat, 400);
        join
        total++; if (lat < 150 || lat > 165) begin bad++; $display("FAIL basic_latency got=%0d exp=155", lat); end
        total++; if (rx_if.o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rx_if.o_valid); end
        total++; if (rx_if.o_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", rx_if.o_data); end
        total++; if ({rx_if.o_frame_err, rx_if.o_parity_err} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {rx_if.o_frame_err, rx_if.o_parity_err}); end
        accept();
        total++; if (rx_if.o_valid !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b exp=0", rx_if.o_valid); end
        tick(32);
    endtask

    task automatic test_parity();
        i_parity_en = 1'b1;
        i_parity_odd = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        tick(4);
        total++; if (rx_if.o_valid !== 1'b1 || rx_if.o_data !== 8'h3C) begin bad++; $display("FAIL par1_data got=%b/%h exp=1/3c", rx_if.o_valid, rx_if.o_data); end
        total++; if (rx_if.o_parity_err !== 1'b1) begin bad++; $display("FAIL par1_err got=%b exp=1", rx_if.o_parity_err); end
        accept();
        tick(16);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        tick(4);
        total++; if (rx_if.o_valid !== 1'b1 || rx_if.o_data !== 8'h3C) begin bad++; $display("FAIL par0_data got=%b/%h exp=1/3c", rx_if.o_valid, rx_if.o_data); end
        total++; if (rx_if.o_parity_err !== 1'b0) begin bad++; $display("FAIL par0_err got=%b exp=0", rx_if.o_parity_err); end
        accept();
        tick(16);
        i_parity_odd = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        tick(4);
        total++; if (rx_if.o_parity_err !== 1'b0 || rx_if.o_valid !== 1'b1) begin bad++; $display("FAIL parodd_err got=%b/%b exp=0/1", rx_if.o_parity_err, rx_if.o_valid); end
        accept();
        tick(16);
        i_parity_en = 1'b0;
        i_parity_odd = 1'b0;
    endtask

    task automatic test_false_start();
        int v0;
        v0 = vrise_cnt;
        i_rx = 1'b0;
        tick(4);
        i_rx = 1'b1;
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b exp=1", o_busy); end
        tick(40);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", o_busy); end
        total++; if (vrise_cnt - v0 !== 0 || rx_if.o_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", vrise_cnt - v0); end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        rx_if.i_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
        tick(16);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16);
        tick(8);
        total++; if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - o0); end
        total++; if (rx_if.o_valid !== 1'b1 || rx_if.o_data !== 8'h11) begin bad++; $display("FAIL overrun_hold got=%b/%h exp=1/11", rx_if.o_valid, rx_if.o_data); end
        accept();
        tick(16);
    endtask

    task automatic test_break();
        int v0;
        int b0;
        v0 = vrise_cnt;
        b0 = brk_cnt;
        i_rx = 1'b0;
        tick(20 * 16);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL break_wait_busy got=%b exp=1", o_busy); end
`ifdef UART_RX_BREAK_DET_EN
        total++; if (brk_cnt - b0 !== 1) begin bad++; $display("FAIL break_pulse got=%0d exp=1", brk_cnt - b0); end
        total++; if (rx_if.o_valid !== 1'b0) begin bad++; $display("FAIL break_valid got=%b exp=0", rx_if.o_valid); end
`else
        total++; if (rx_if.o_valid !== 1'b1 || rx_if.o_data !== 8'h00) begin bad++; $display("FAIL break_data got=%b/%h exp=1/00", rx_if.o_valid, rx_if.o_data); end
        total++; if (rx_if.o_frame_err !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b exp=1", rx_if.o_frame_err); end
`endif
        i_rx = 1'b1;
        tick(8);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL break_release_busy got=%b exp=0", o_busy); end
`ifdef UART_RX_BREAK_DET_EN
        total++; if (vrise_cnt - v0 !== 0) begin bad++; $display("FAIL break_retrigger got=%0d exp=0", vrise_cnt - v0); end
`else
        total++; if (vrise_cnt - v0 !== 1) begin bad++; $display("FAIL break_retrigger got=%0d exp=1", vrise_cnt - v0); end
        accept();
`endif
        tick(16);
    endtask

    task automatic test_reset_mid_and_small_div();
        i_div_num = 24'd16;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16);
        tick(4);
        total++; if (rx_if.o_valid !== 1'b1 || rx_if.o_data !== 8'hC3) begin bad++; $display("FAIL pre_reset_data got=%b/%h exp=1/c3", rx_if.o_valid, rx_if.o_data); end
        i_rx = 1'b0;
        tick(16);
        i_rx = 1'b1; tick(16);
        i_rx = 1'b0; tick(16);
        i_rx = 1'b1; tick(16);
        i_rx = 1'b0; tick(8);
        reset = 1'b0;
        #1;
        total++; if (rx_if.o_valid !== 1'b0 || rx_if.o_data !== 8'h00) begin bad++; $display("FAIL midreset_data got=%b/%h exp=0/00", rx_if.o_valid, rx_if.o_data); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", o_busy); end
        i_rx = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(4);
        i_div_num = 24'd1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1);
        tick(4);
        total++; if (rx_if.o_valid !== 1'b1 || rx_if.o_data !== 8'h5A) begin bad++; $display("FAIL smalldiv_data got=%b/%h exp=1/5a", rx_if.o_valid, rx_if.o_data); end
        total++; if (rx_if.o_frame_err !== 1'b0) begin bad++; $display("FAIL smalldiv_ferr got=%b exp=0", rx_if.o_frame_err); end
        accept();
        tick(8);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_overrun();
        test_break();
        test_reset_mid_and_small_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
